// File: rtl/dc_pattern_source_ipu.sv
// Test-pattern frame source for the IPU pixel stream: solid, gradient,
// checkerboard and 8-bar colour bars over an IMG_WIDTH x IMG_HEIGHT raster.
module dc_pattern_source_ipu #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int FRAME_GAP  = 4,
    parameter int CHK_SHIFT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [23:0] solid_color,
    output logic        pixel_valid,
    input  logic        pixel_ready,
    output logic [23:0] pixel_data,
    output logic        pixel_sof,
    output logic        pixel_eol,
    output logic        frame_done,
    output logic        busy,
    output logic [15:0] frame_cnt
);
    localparam logic [11:0] X_LAST   = 12'(IMG_WIDTH - 1);
    localparam logic [11:0] Y_LAST   = 12'(IMG_HEIGHT - 1);
    localparam logic [11:0] BAR_LAST = 12'(IMG_WIDTH / 8 - 1);
    localparam logic [15:0] GAP_LAST = 16'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

    state_t      state;
    logic [11:0] x, y, bar_pos;
    logic [2:0]  bar;
    logic [15:0] gap_cnt;
    logic [1:0]  mode_q;
    logic [23:0] color_q;

    logic        xfer, last, start, advance;
    logic [11:0] n_x, n_y, n_bar_pos;
    logic [2:0]  n_bar;
    logic [1:0]  n_mode;
    logic [23:0] n_color, n_data;
    logic [7:0]  n_sum;

    // Next presented pixel: either (0,0) of a new frame or the raster successor.
    always_comb begin
        xfer    = (state == RUN) && pixel_valid && pixel_ready;
        last    = xfer && (x == X_LAST) && (y == Y_LAST);
        start   = enable && ((state == IDLE) ||
                             ((state == GAP) && (gap_cnt == GAP_LAST)) ||
                             (last && (FRAME_GAP == 0)));
        advance = xfer && !last;

        n_mode  = start ? mode : mode_q;
        n_color = start ? solid_color : color_q;

        n_x       = '0;
        n_y       = '0;
        n_bar     = '0;
        n_bar_pos = '0;
        if (advance) begin
            if (x == X_LAST) begin
                n_y = y + 12'd1;
            end else begin
                n_x = x + 12'd1;
                n_y = y;
                if (bar_pos == BAR_LAST) begin
                    n_bar = bar + 3'd1;
                end else begin
                    n_bar     = bar;
                    n_bar_pos = bar_pos + 12'd1;
                end
            end
        end

        n_sum  = n_x[7:0] + n_y[7:0];
        n_data = '0;
        case (n_mode)
            2'd0: n_data = n_color;
            2'd1: n_data = {n_sum, n_y[7:0], n_x[7:0]};
            2'd2: n_data = (n_x[CHK_SHIFT] ^ n_y[CHK_SHIFT]) ? 24'h000000 : 24'hFFFFFF;
            default: begin
                case (n_bar)
                    3'd0:    n_data = 24'hFFFFFF;
                    3'd1:    n_data = 24'h00FFFF;
                    3'd2:    n_data = 24'hFFFF00;
                    3'd3:    n_data = 24'h00FF00;
                    3'd4:    n_data = 24'hFF00FF;
                    3'd5:    n_data = 24'h0000FF;
                    3'd6:    n_data = 24'hFF0000;
                    default: n_data = 24'h000000;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            bar         <= '0;
            bar_pos     <= '0;
            gap_cnt     <= '0;
            mode_q      <= '0;
            color_q     <= '0;
            pixel_valid <= 1'b0;
            pixel_data  <= '0;
            pixel_sof   <= 1'b0;
            pixel_eol   <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            frame_done <= 1'b0;
            if (start || advance) begin
                x          <= n_x;
                y          <= n_y;
                bar        <= n_bar;
                bar_pos    <= n_bar_pos;
                mode_q     <= n_mode;
                color_q    <= n_color;
                pixel_data <= n_data;
                pixel_sof  <= start;
                pixel_eol  <= (n_x == X_LAST);
            end
            if (last) begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (enable) begin
                        state       <= RUN;
                        pixel_valid <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                RUN: begin
                    if (last) begin
                        if (FRAME_GAP > 0) begin
                            state       <= GAP;
                            gap_cnt     <= '0;
                            pixel_valid <= 1'b0;
                        end else if (!enable) begin
                            state       <= IDLE;
                            pixel_valid <= 1'b0;
                            busy        <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state       <= enable ? RUN : IDLE;
                        pixel_valid <= enable;
                        busy        <= enable;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dc_pattern_source_ipu.sv
// Bench for dc_pattern_source_ipu: three parameterisations share stimulus; captured
// frames are checked against a coordinate-level pattern model and a fixed vector table.
module tb_dc_pattern_source_ipu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        pixel_ready = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [23:0] solid_color = 24'h0;

    logic        v[3], sof[3], eol[3], dn[3], bz[3];
    logic [23:0] d[3];
    logic [15:0] fc[3];

    always #5 clk = ~clk;

    // a: 8x8 gap 4, b: 16x8 gap 4, c: 8x8 gap 0
    dc_pattern_source_ipu #(.IMG_WIDTH(8), .IMG_HEIGHT(8), .FRAME_GAP(4), .CHK_SHIFT(1)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .solid_color(solid_color),
        .pixel_valid(v[0]), .pixel_ready(pixel_ready), .pixel_data(d[0]), .pixel_sof(sof[0]),
        .pixel_eol(eol[0]), .frame_done(dn[0]), .busy(bz[0]), .frame_cnt(fc[0]));
    dc_pattern_source_ipu #(.IMG_WIDTH(16), .IMG_HEIGHT(8), .FRAME_GAP(4), .CHK_SHIFT(1)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .solid_color(solid_color),
        .pixel_valid(v[1]), .pixel_ready(pixel_ready), .pixel_data(d[1]), .pixel_sof(sof[1]),
        .pixel_eol(eol[1]), .frame_done(dn[1]), .busy(bz[1]), .frame_cnt(fc[1]));
    dc_pattern_source_ipu #(.IMG_WIDTH(8), .IMG_HEIGHT(8), .FRAME_GAP(0), .CHK_SHIFT(1)) dut_c (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode), .solid_color(solid_color),
        .pixel_valid(v[2]), .pixel_ready(pixel_ready), .pixel_data(d[2]), .pixel_sof(sof[2]),
        .pixel_eol(eol[2]), .frame_done(dn[2]), .busy(bz[2]), .frame_cnt(fc[2]));

    int n_tests = 0;
    int n_fail  = 0;

    logic [23:0] cap_d[$];
    logic        cap_sof[$], cap_eol[$];
    int          done_fc[$];
    int          done_sof, stall_bad;
    logic [23:0] fr_grad[64], fr_bar[128], fr_chk[64];

    typedef struct { int src; int x; int y; logic [23:0] exp; } vec_t;
    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] model(input int m, input logic [23:0] c, input int x,
                                          input int y, input int w);
        logic [23:0] r;
        case (m)
            0: r = c;
            1: r = {8'((x + y) % 256), 8'(y % 256), 8'(x % 256)};
            2: r = ((((x >> 1) ^ (y >> 1)) & 1) == 0) ? 24'hFFFFFF : 24'h000000;
            default: begin
                case (x / (w / 8))
                    0: r = 24'hFFFFFF;
                    1: r = 24'h00FFFF;
                    2: r = 24'hFFFF00;
                    3: r = 24'h00FF00;
                    4: r = 24'hFF00FF;
                    5: r = 24'h0000FF;
                    6: r = 24'hFF0000;
                    default: r = 24'h000000;
                endcase
            end
        endcase
        return r;
    endfunction

    function automatic int mism(input int m, input logic [23:0] c, input int w, input int h);
        int bad = 0;
        foreach (cap_d[i]) if (cap_d[i] !== model(m, c, i % w, (i / w) % h, w)) bad++;
        return bad;
    endfunction

    function automatic int pos_bad(input int w, input int h);
        int bad = 0;
        foreach (cap_d[i]) begin
            if (cap_sof[i] !== (i % (w * h) == 0)) bad++;
            if (cap_eol[i] !== (i % w == w - 1)) bad++;
        end
        return bad;
    endfunction

    function automatic logic [23:0] pick(input int src, input int x, input int y);
        case (src)
            0:       return fr_grad[y * 8 + x];
            1:       return fr_bar[y * 16 + x];
            default: return fr_chk[y * 8 + x];
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; enable = 1'b0; pixel_ready = 1'b0; mode = 2'd0; solid_color = 24'h0;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic pulse_enable();
        enable = 1'b1;
        step(1);
        enable = 1'b0;
    endtask

    // Collect n transfers from DUT s; called and returns #1 after a rising edge.
    task automatic collect(input int s, input int n, input int rdy_pct, input int chg_idx,
                           input int drop_idx, output int cycles);
        logic        p_stall = 1'b0;
        logic [23:0] p_d = '0;
        logic        p_sof = 1'b0, p_eol = 1'b0;
        int          got = 0;
        cap_d.delete(); cap_sof.delete(); cap_eol.delete(); done_fc.delete();
        done_sof = 0; stall_bad = 0; cycles = 0;
        while (got < n && cycles < 4000) begin
            if (p_stall && (!v[s] || d[s] !== p_d || sof[s] !== p_sof || eol[s] !== p_eol))
                stall_bad++;
            if (dn[s]) begin
                done_fc.push_back(int'(fc[s]));
                if (v[s] && sof[s]) done_sof++;
            end
            pixel_ready = ($urandom_range(99) < rdy_pct);
            if (v[s] && pixel_ready) begin
                cap_d.push_back(d[s]); cap_sof.push_back(sof[s]); cap_eol.push_back(eol[s]);
                if (got == chg_idx) begin mode = 2'd1; solid_color = 24'h0; end
                if (got == drop_idx) enable = 1'b0;
                got++;
            end
            p_stall = v[s] && !pixel_ready;
            p_d = d[s]; p_sof = sof[s]; p_eol = eol[s];
            cycles++;
            step(1);
        end
        chk($sformatf("xfer_count_dut%0d", s), got, n);
    endtask

    initial begin
        int cyc, bad, uniq;
        logic seen[64];

        tbl[0]  = '{0, 3, 5, 24'h080503};
        tbl[1]  = '{0, 0, 0, 24'h000000};
        tbl[2]  = '{0, 7, 7, 24'h0E0707};
        tbl[3]  = '{0, 6, 2, 24'h080206};
        tbl[4]  = '{1, 0, -1, 24'hFFFFFF};
        tbl[5]  = '{1, 1, -1, 24'hFFFFFF};
        tbl[6]  = '{1, 2, -1, 24'h00FFFF};
        tbl[7]  = '{1, 5, -1, 24'hFFFF00};
        tbl[8]  = '{1, 10, -1, 24'h0000FF};
        tbl[9]  = '{1, 15, -1, 24'h000000};
        tbl[10] = '{2, 0, 0, 24'hFFFFFF};
        tbl[11] = '{2, 2, 0, 24'h000000};
        tbl[12] = '{2, 2, 2, 24'hFFFFFF};
        tbl[13] = '{2, 1, 3, 24'h000000};

        do_reset();
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("reset_flags_dut%0d", s), {v[s], sof[s], eol[s], dn[s], bz[s]}, 0);
            chk($sformatf("reset_data_dut%0d", s), d[s], 0);
            chk($sformatf("reset_cnt_dut%0d", s), fc[s], 0);
        end

        // gradient, full-rate, single frame, then gap and idle
        mode = 2'd1; pixel_ready = 1'b1;
        pulse_enable();
        chk("start_latency_valid_sof", {v[0], sof[0]}, 2'b11);
        collect(0, 64, 100, -1, -1, cyc);
        chk("grad_cycles", cyc, 64);
        chk("grad_model", mism(1, 0, 8, 8), 0);
        chk("grad_sof_eol", pos_bad(8, 8), 0);
        for (int i = 0; i < 64; i++) fr_grad[i] = (i < cap_d.size()) ? cap_d[i] : 'x;
        chk("grad_done_valid_busy", {dn[0], v[0], bz[0]}, 3'b101);
        chk("grad_frame_cnt", fc[0], 1);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (dn[0] || v[0] || !bz[0]) bad++;
        end
        chk("grad_gap_cycles", bad, 0);
        step(1);
        chk("grad_back_to_idle", {v[0], bz[0]}, 0);

        // colour bars on 16x8
        do_reset();
        mode = 2'd3; pixel_ready = 1'b1;
        pulse_enable();
        collect(1, 128, 100, -1, -1, cyc);
        chk("bars_model", mism(3, 0, 16, 8), 0);
        chk("bars_sof_eol", pos_bad(16, 8), 0);
        for (int i = 0; i < 128; i++) fr_bar[i] = (i < cap_d.size()) ? cap_d[i] : 'x;

        // checkerboard under random backpressure
        do_reset();
        mode = 2'd2;
        pulse_enable();
        collect(0, 64, 40, -1, -1, cyc);
        chk("chk_stall_stable", stall_bad, 0);
        chk("chk_model", mism(2, 0, 8, 8), 0);
        chk("chk_sof_eol", pos_bad(8, 8), 0);
        chk("chk_done_after_64", dn[0], 1);
        for (int i = 0; i < 64; i++) fr_chk[i] = (i < cap_d.size()) ? cap_d[i] : 'x;

        // gradient under backpressure: every coordinate exactly once
        do_reset();
        mode = 2'd1;
        pulse_enable();
        collect(0, 64, 50, -1, -1, cyc);
        chk("bp_stall_stable", stall_bad, 0);
        foreach (seen[i]) seen[i] = 1'b0;
        uniq = 0;
        foreach (cap_d[i]) begin
            if (cap_d[i][7:0] < 8 && cap_d[i][15:8] < 8 &&
                !seen[cap_d[i][15:8] * 8 + cap_d[i][7:0]]) begin
                seen[cap_d[i][15:8] * 8 + cap_d[i][7:0]] = 1'b1;
                uniq++;
            end
        end
        chk("bp_unique_coords", uniq, 64);
        chk("bp_model", mism(1, 0, 8, 8), 0);

        // mid-frame mode/colour change waits for the next frame
        do_reset();
        mode = 2'd0; solid_color = 24'h123456; pixel_ready = 1'b1;
        pulse_enable();
        collect(0, 64, 100, 10, -1, cyc);
        chk("solid_held_frame", mism(0, 24'h123456, 8, 8), 0);
        step(4);
        pulse_enable();
        collect(0, 64, 100, -1, -1, cyc);
        chk("solid_next_is_grad", mism(1, 0, 8, 8), 0);
        chk("solid_frame_cnt", fc[0], 2);

        // reset while stalled mid-frame
        step(4);
        pulse_enable();
        collect(0, 30, 100, -1, -1, cyc);
        pixel_ready = 1'b0;
        step(1);
        chk("stall_pixel30_valid", v[0], 1);
        chk("stall_pixel30_data", d[0], 24'h090306);
        chk("pre_rst_cnt", fc[0], 2);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_flags", {v[0], sof[0], eol[0], dn[0], bz[0]}, 0);
        chk("rst_async_data_cnt", {d[0], fc[0]}, 0);
        enable = 1'b1; pixel_ready = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
        chk("post_rst_first_pixel", {v[0], sof[0], eol[0], d[0]}, {3'b110, 24'h000000});
        step(1);
        chk("post_rst_second_pixel", {v[0], sof[0], d[0]}, {2'b10, 24'h010001});
        enable = 1'b0;

        // FRAME_GAP = 0: back-to-back frames, enable dropped inside frame 4
        do_reset();
        mode = 2'd1; pixel_ready = 1'b1; enable = 1'b1;
        step(1);
        collect(2, 256, 100, -1, 212, cyc);
        chk("b2b_no_bubble", cyc, 256);
        chk("b2b_model", mism(1, 0, 8, 8), 0);
        chk("b2b_sof_eol", pos_bad(8, 8), 0);
        chk("b2b_done_pulses", done_fc.size(), 3);
        bad = 0;
        foreach (done_fc[i]) if (done_fc[i] != i + 1) bad++;
        chk("b2b_frame_cnt_seq", bad, 0);
        chk("b2b_done_with_sof", done_sof, 3);
        chk("b2b_final_done_cnt", {dn[2], fc[2]}, {1'b1, 16'd4});
        chk("b2b_final_idle", {v[2], bz[2]}, 0);

        foreach (tbl[k]) begin
            if (tbl[k].y >= 0) begin
                chk($sformatf("vec%0d_src%0d_x%0d_y%0d", k, tbl[k].src, tbl[k].x, tbl[k].y),
                    pick(tbl[k].src, tbl[k].x, tbl[k].y), tbl[k].exp);
            end else begin
                bad = 0;
                for (int yy = 0; yy < 8; yy++)
                    if (pick(tbl[k].src, tbl[k].x, yy) !== tbl[k].exp) bad++;
                chk($sformatf("vec%0d_src%0d_x%0d_all_lines", k, tbl[k].src, tbl[k].x), bad, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dc_pattern_source_ipu.md
# dc_pattern_source_ipu

Synthesizable frame source that drives the image-processing-unit pixel stream with generated test patterns: solid color, gradient, checkerboard and 8-bar color bars. It sits upstream of any pixel sink using the valid/ready pixel handshake, e.g. the IPU input or the IPU dumper, and provides stimulus for scaler bring-up in simulation and on hardware. Frames are `IMG_WIDTH`×`IMG_HEIGHT` pixels, raster order, one 24-bit pixel per accepted transfer.

## Interface
Parameters:
- `IMG_WIDTH`, 8: pixels per line; must be a multiple of 8 and ≤ 4096.
- `IMG_HEIGHT`, 8: lines per frame; ≤ 4096.
- `FRAME_GAP`, 4: idle cycles between consecutive frames; 0 allowed.
- `CHK_SHIFT`, 1: checkerboard square size is 2^`CHK_SHIFT` pixels.

Ports:
- `clk`  in  1  clock. One clock domain; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  level; while high, frames are generated continuously.
- `mode`  in  2  pattern select: 0 solid, 1 gradient, 2 checkerboard, 3 color bars.
- `solid_color`  in  24  pixel value used by mode 0.
- `pixel_valid`  out  1  pixel available.
- `pixel_ready`  in  1  sink accepts the pixel.
- `pixel_data`  out  24  {b[23:16], g[15:8], r[7:0]}.
- `pixel_sof`  out  1  current pixel is (x=0, y=0).
- `pixel_eol`  out  1  current pixel is x = `IMG_WIDTH`-1.
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame transfers.
- `busy`  out  1  high when the state is not IDLE.
- `frame_cnt`  out  16  completed frames; wraps from 0xFFFF to 0.

## Operation
- States:
  - IDLE → RUN when `enable`=1.
  - RUN → GAP after the last pixel transfers, if `FRAME_GAP`>0.
  - RUN → RUN after the last pixel transfers, if `FRAME_GAP`=0 and `enable`=1.
  - RUN → IDLE after the last pixel transfers, if `FRAME_GAP`=0 and `enable`=0.
  - GAP → RUN or IDLE, selected by `enable`, after `FRAME_GAP` cycles.
- A transfer occurs when `pixel_valid` & `pixel_ready`. Coordinates x and y advance only on a transfer: x wraps at `IMG_WIDTH`-1 and increments y; y wraps at `IMG_HEIGHT`-1 and ends the frame.
- `mode` and `solid_color` are latched on entry to RUN. Changes mid-frame have no effect until the next frame.
- Deasserting `enable` mid-frame does not truncate the frame. The frame completes, then the block goes to GAP/IDLE.
- Pattern values (r, g, b):
  - Mode 0: `solid_color`.
  - Mode 1: r = x[7:0], g = y[7:0], b = (x+y)[7:0] (mod 256).
  - Mode 2: 0xFFFFFF if ((x>>`CHK_SHIFT`) ^ (y>>`CHK_SHIFT`)) bit0 = 0, else 0x000000.
  - Mode 3: bar = x / (`IMG_WIDTH`/8), computed with a bar-width counter, not a divider. `pixel_data` per bar 0..7: 0xFFFFFF, 0x00FFFF, 0xFFFF00, 0x00FF00, 0xFF00FF, 0x0000FF, 0xFF0000, 0x000000.
- `frame_cnt` increments in the same cycle `frame_done` is high.

## Timing
- Reset values: `pixel_valid`=0, `pixel_data`=0, `pixel_sof`=0, `pixel_eol`=0, `frame_done`=0, `busy`=0, `frame_cnt`=0. State IDLE, x=y=0.
- Reset mid-frame clears everything asynchronously. After release, a new frame starts from (0,0).
- Start latency: `enable` sampled high in IDLE → `pixel_valid`=1 with pixel (0,0) and `pixel_sof`=1 on the next cycle.
- All outputs are registered.
- While `pixel_valid`=1 and `pixel_ready`=0, `pixel_data`, `pixel_sof` and `pixel_eol` hold stable. `pixel_valid` never drops without a transfer, except on reset.
- With `pixel_ready` held at 1, throughput is one pixel per cycle with no bubbles inside a frame.
- Frame end:
  - `frame_done` pulses the cycle after the last transfer.
  - With `FRAME_GAP`>0, `pixel_valid`=0 for exactly `FRAME_GAP` cycles after the last transfer. The next (0,0) appears on the following cycle if `enable`=1.
  - With `FRAME_GAP`=0 and `enable`=1, the next frame's (0,0) is valid the cycle after the last transfer, concurrent with `frame_done`.
- `busy` is high from the first RUN cycle through the last GAP cycle.

## Test plan
- Reset, then mode 1 with 8×8, `pixel_ready`=1, `enable` pulsed:
  - 64 transfers in 64 consecutive cycles.
  - Pixel (3,5) = 0x080503.
  - `pixel_sof` only on the first pixel; `pixel_eol` on every 8th pixel.
  - One `frame_done` pulse; `frame_cnt`=1; returns to IDLE after 4 gap cycles.
- Mode 3 with 16×8:
  - x=0,1 → 0xFFFFFF; x=2 → 0x00FFFF; x=10 → 0x0000FF; x=15 → 0x000000.
  - Same values on every line.
- Mode 2, `CHK_SHIFT`=1:
  - (0,0) = 0xFFFFFF; (2,0) = 0x000000; (2,2) = 0xFFFFFF.
  - Random `pixel_ready` backpressure: `pixel_data` stable while stalled; no pixel lost or duplicated (64 unique coordinates checked).
- Mode 0 with `solid_color`=0x123456:
  - Change to `mode`=1 and `solid_color`=0 at pixel 10 → whole frame stays 0x123456.
  - Next frame is the gradient.
- `enable` held high, `FRAME_GAP`=0, `pixel_ready`=1:
  - 3 frames back-to-back with no bubble.
  - `frame_cnt` goes 1, 2, 3.
  - `enable` dropped at pixel 20 of frame 4 → frame 4 completes all 64 pixels, then IDLE.
- Assert `rst` at pixel 30 while `pixel_ready`=0:
  - `pixel_valid`=0 and `frame_cnt`=0 immediately.
  - After release with `enable`=1, the first pixel is (0,0) with `pixel_sof`=1.
